// File: rtl/spi_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_pkg
//  Purpose  : Shared header codes, payload lengths and transaction types for
//             the SPI frame receiver.
//  Revision : 1.0  initial release
// ============================================================================
package spi_frame_pkg;

    localparam logic [7:0] c_hdr_start = 8'h5A;
    localparam logic [7:0] c_hdr_cfg   = 8'hC3;
    localparam logic [7:0] c_hdr_read  = 8'h3C;

    localparam int c_cfg_len  = 8;
    localparam int c_read_len = 10;
    localparam int c_pay_w    = 10;

    typedef enum logic [1:0] {
        TXN_START = 2'd0,
        TXN_CFG   = 2'd1,
        TXN_READ  = 2'd2
    } txn_type_t;

endpackage
`default_nettype wire

// File: rtl/spi_rx_outbuf.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rx_outbuf
//  Purpose  : One-entry valid/ready holding register for decoded transactions,
//             flags a completion that finds the entry still unaccepted.
//  Revision : 1.0  initial release
// ============================================================================
module spi_rx_outbuf
    import spi_frame_pkg::*;
#(
    parameter int PAY_W = c_pay_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [1:0]       i_type,
    input  logic [7:0]       i_head,
    input  logic [PAY_W-1:0] i_payload,
    input  logic             i_txn_ready,
    output logic             o_txn_valid,
    output logic [1:0]       o_txn_type,
    output logic [7:0]       o_txn_head,
    output logic [PAY_W-1:0] o_txn_payload,
    output logic             o_err_overflow
);

    logic             r_valid;
    logic [1:0]       r_type;
    logic [7:0]       r_head;
    logic [PAY_W-1:0] r_payload;
    logic             r_overflow;
    logic             w_blocked;

    // An unaccepted entry that is not being taken this edge cannot be replaced.
    assign w_blocked = r_valid && !i_txn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_type     <= 2'd0;
            r_head     <= 8'd0;
            r_payload  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_load && w_blocked;
            if (i_load && !w_blocked) begin
                r_valid   <= 1'b1;
                r_type    <= i_type;
                r_head    <= i_head;
                r_payload <= i_payload;
            end else if (i_txn_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_txn_valid    = r_valid;
    assign o_txn_type     = r_type;
    assign o_txn_head     = r_head;
    assign o_txn_payload  = r_payload;
    assign o_err_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_rx
//  Purpose  : Serial frame receiver: header/payload decode into START, CFG and
//             READ transactions with illegal, length, overflow, suspend errors.
//  Revision : 1.0  initial release
// ============================================================================
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter logic [7:0] HDR_START = c_hdr_start,
    parameter logic [7:0] HDR_CFG   = c_hdr_cfg,
    parameter logic [7:0] HDR_READ  = c_hdr_read,
    parameter int         CFG_LEN   = c_cfg_len,
    parameter int         READ_LEN  = c_read_len,
    parameter int         SUS_MAX   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame,
    input  logic         serial,
    input  logic         suspend,
    output logic         txn_valid,
    input  logic         txn_ready,
    output logic [1:0]   txn_type,
    output logic [7:0]   txn_head,
    output logic [9:0]   txn_payload,
    output logic         err_illegal,
    output logic         err_length,
    output logic         err_overflow,
    output logic         err_suspend
);

    localparam logic [3:0] c_cfg_last  = 4'(CFG_LEN - 1);
    localparam logic [3:0] c_read_last = 4'(READ_LEN - 1);
    localparam int         c_sus_w     = $clog2(SUS_MAX + 1);
    localparam logic [c_sus_w-1:0] c_sus_lim = c_sus_w'(SUS_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_END     = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_frame;
    logic                r_seen_low;
    logic [2:0]          r_hidx;
    logic [3:0]          r_pidx;
    logic [3:0]          r_plast;
    logic [7:0]          r_head;
    logic [c_pay_w-1:0]  r_payload;
    txn_type_t           r_type;
    logic [c_sus_w-1:0]  r_sus_cnt;
    logic                r_err_illegal;
    logic                r_err_length;
    logic                r_err_suspend;

    logic                w_qual;
    logic [7:0]          w_head_full;
    logic                w_begin;
    logic                w_hdr_bit;
    logic                w_hdr_done;
    logic                w_pay_bit;
    logic                w_complete;
    logic                w_ill;
    logic                w_len;
    txn_type_t           w_type_nxt;
    logic [3:0]          w_plast_nxt;

    assign w_qual      = !suspend;
    // Header decision sees the final bit before it is registered.
    assign w_head_full = {serial, r_head[6:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_begin     = 1'b0;
        w_hdr_bit   = 1'b0;
        w_hdr_done  = 1'b0;
        w_pay_bit   = 1'b0;
        w_complete  = 1'b0;
        w_ill       = 1'b0;
        w_len       = 1'b0;
        w_type_nxt  = TXN_START;
        w_plast_nxt = 4'd0;
        if (w_qual) begin
            case (r_state)
                S_IDLE: begin
                    if (frame && !r_last_frame && r_seen_low) begin
                        w_state_nxt = S_HEADER;
                        w_begin     = 1'b1;
                    end
                end
                S_HEADER: begin
                    if (!frame) begin
                        w_len       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_hdr_bit = 1'b1;
                        if (r_hidx == 3'd7) begin
                            if (w_head_full == HDR_START) begin
                                w_hdr_done  = 1'b1;
                                w_type_nxt  = TXN_START;
                                w_state_nxt = S_END;
                            end else if (w_head_full == HDR_CFG) begin
                                w_hdr_done  = 1'b1;
                                w_type_nxt  = TXN_CFG;
                                w_plast_nxt = c_cfg_last;
                                w_state_nxt = S_PAYLOAD;
                            end else if (w_head_full == HDR_READ) begin
                                w_hdr_done  = 1'b1;
                                w_type_nxt  = TXN_READ;
                                w_plast_nxt = c_read_last;
                                w_state_nxt = S_PAYLOAD;
                            end else begin
                                w_ill       = 1'b1;
                                w_state_nxt = S_DRAIN;
                            end
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (!frame) begin
                        w_len       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pay_bit = 1'b1;
                        if (r_pidx == r_plast) begin
                            w_state_nxt = S_END;
                        end
                    end
                end
                S_END: begin
                    if (!frame) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_len       = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!frame) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_frame  <= 1'b0;
            r_seen_low    <= 1'b0;
            r_hidx        <= 3'd0;
            r_pidx        <= 4'd0;
            r_plast       <= 4'd0;
            r_head        <= 8'd0;
            r_payload     <= '0;
            r_type        <= TXN_START;
            r_sus_cnt     <= '0;
            r_err_illegal <= 1'b0;
            r_err_length  <= 1'b0;
            r_err_suspend <= 1'b0;
        end else begin
            r_err_illegal <= w_ill;
            r_err_length  <= w_len;
            r_err_suspend <= suspend && (r_sus_cnt == c_sus_lim - c_sus_w'(1));
            if (suspend) begin
                if (r_sus_cnt != c_sus_lim) begin
                    r_sus_cnt <= r_sus_cnt + c_sus_w'(1);
                end
            end else begin
                r_sus_cnt <= '0;
            end
            if (w_qual) begin
                r_last_frame <= frame;
                // A start is only trusted once frame has been seen low since reset.
                if (!frame) begin
                    r_seen_low <= 1'b1;
                end
                if (w_begin) begin
                    r_hidx    <= 3'd0;
                    r_pidx    <= 4'd0;
                    r_payload <= '0;
                end
                if (w_hdr_bit) begin
                    r_head[r_hidx] <= serial;
                    r_hidx         <= r_hidx + 3'd1;
                end
                if (w_hdr_done) begin
                    r_type  <= w_type_nxt;
                    r_plast <= w_plast_nxt;
                end
                if (w_pay_bit) begin
                    r_payload[r_pidx] <= serial;
                    r_pidx            <= r_pidx + 4'd1;
                end
            end
        end
    end

    spi_rx_outbuf #(
        .PAY_W (c_pay_w)
    ) u_outbuf (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_complete),
        .i_type         (r_type),
        .i_head         (r_head),
        .i_payload      (r_payload),
        .i_txn_ready    (txn_ready),
        .o_txn_valid    (txn_valid),
        .o_txn_type     (txn_type),
        .o_txn_head     (txn_head),
        .o_txn_payload  (txn_payload),
        .o_err_overflow (err_overflow)
    );

    assign err_illegal = r_err_illegal;
    assign err_length  = r_err_length;
    assign err_suspend = r_err_suspend;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_rx
//  Purpose  : Randomised scoreboard bench for spi_frame_rx with a frame-level
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_frame_rx;
    import spi_frame_pkg::*;

    localparam int SUS_MAX = 4;

    typedef struct {
        logic [1:0] t;
        logic [7:0] h;
        logic [9:0] p;
    } txn_s;

    logic       clk = 1'b0;
    logic       rst, frame, serial, suspend, txn_ready;
    logic       txn_valid;
    logic [1:0] txn_type;
    logic [7:0] txn_head;
    logic [9:0] txn_payload;
    logic       err_illegal, err_length, err_overflow, err_suspend;

    txn_s exp_q[$];
    int   n_checks = 0, n_pass = 0;
    int   exp_ill = 0, exp_len = 0, exp_ovf = 0, exp_sus = 0;
    int   obs_ill = 0, obs_len = 0, obs_ovf = 0, obs_sus = 0;
    int   sus_run = 0;
    bit   busy = 0, hold_ready = 0, force_ready = 0, rnd_sus = 0;

    always #5 clk = ~clk;

    spi_frame_rx dut (
        .clk          (clk),
        .rst          (rst),
        .frame        (frame),
        .serial       (serial),
        .suspend      (suspend),
        .txn_valid    (txn_valid),
        .txn_ready    (txn_ready),
        .txn_type     (txn_type),
        .txn_head     (txn_head),
        .txn_payload  (txn_payload),
        .err_illegal  (err_illegal),
        .err_length   (err_length),
        .err_overflow (err_overflow),
        .err_suspend  (err_suspend)
    );

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: counts error pulses, checks hold stability and pops the scoreboard.
    logic       prev_hold = 1'b0;
    logic [1:0] pt;
    logic [7:0] ph;
    logic [9:0] pp;
    always @(negedge clk) begin
        txn_s e;
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (err_illegal)  obs_ill <= obs_ill + 1;
            if (err_length)   obs_len <= obs_len + 1;
            if (err_overflow) obs_ovf <= obs_ovf + 1;
            if (err_suspend)  obs_sus <= obs_sus + 1;
            if (prev_hold)
                chk("hold", txn_valid === 1'b1 && txn_type === pt && txn_head === ph && txn_payload === pp,
                    {txn_valid, txn_type, txn_head, txn_payload}, {1'b1, pt, ph, pp});
            if (txn_valid && txn_ready) begin
                if (exp_q.size() == 0) begin
                    chk("txn_unexpected", 1'b0, {txn_type, txn_head, txn_payload}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn", {txn_type, txn_head, txn_payload} === {e.t, e.h, e.p},
                        {txn_type, txn_head, txn_payload}, {e.t, e.h, e.p});
                end
            end
            prev_hold <= txn_valid && !txn_ready;
            pt <= txn_type;
            ph <= txn_head;
            pp <= txn_payload;
        end
    end

    // One clock of stimulus; the model applies the handshake/overflow rules for that edge.
    task automatic cyc(input logic f, input logic s, input logic sus, input bit comp, input txn_s e);
        logic r;
        r = hold_ready ? 1'b0 : (force_ready ? 1'b1 : rb());
        frame = f; serial = s; suspend = sus; txn_ready = r;
        if (sus) begin
            if (sus_run < SUS_MAX) begin
                sus_run++;
                if (sus_run == SUS_MAX) exp_sus++;
            end
        end else begin
            sus_run = 0;
        end
        if (comp && !sus) begin
            if (busy && !r) exp_ovf++;
            else begin exp_q.push_back(e); busy = 1; end
        end else if (busy && r) begin
            busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic sus);
        txn_s e;
        e.t = 2'd0; e.h = 8'd0; e.p = 10'd0;
        repeat (n) cyc(1'b0, rb(), sus, 1'b0, e);
    endtask

    task automatic send_frame(input logic [7:0] h, input int hbits, input int n, input logic [15:0] pb,
                              input int sus_at, input int sus_len, input int gap);
        logic fq[$];
        logic sq[$];
        txn_s e;
        int   len;
        bit   legal, comp_ok;
        legal = 1; len = 0; comp_ok = 0;
        e.h = h; e.t = 2'd0; e.p = 10'd0;
        if (h == c_hdr_start)     begin len = 0;  e.t = 2'd0; end
        else if (h == c_hdr_cfg)  begin len = 8;  e.t = 2'd1; e.p = {2'b00, pb[7:0]}; end
        else if (h == c_hdr_read) begin len = 10; e.t = 2'd2; e.p = pb[9:0]; end
        else legal = 0;
        if (hbits < 8)      exp_len++;
        else if (!legal)    exp_ill++;
        else if (n == len)  comp_ok = 1;
        else                exp_len++;
        fq.push_back(1'b1); sq.push_back(rb());
        for (int i = 0; i < hbits; i++) begin fq.push_back(1'b1); sq.push_back(h[i]); end
        if (hbits == 8)
            for (int j = 0; j < n; j++) begin fq.push_back(1'b1); sq.push_back(pb[j]); end
        fq.push_back(1'b0); sq.push_back(rb());
        for (int k = 0; k < fq.size(); k++) begin
            if (k == sus_at) repeat (sus_len) cyc(rb(), rb(), 1'b1, 1'b0, e);
            if (rnd_sus && $urandom_range(0, 9) == 0) repeat ($urandom_range(1, 5)) cyc(rb(), rb(), 1'b1, 1'b0, e);
            cyc(fq[k], sq[k], 1'b0, comp_ok && (k == fq.size() - 1), e);
        end
        idle(gap, 1'b0);
    endtask

    task automatic check_errs(input string tag);
        idle(3, 1'b0);
        chk({tag, "_err_illegal"},  obs_ill == exp_ill, obs_ill, exp_ill);
        chk({tag, "_err_length"},   obs_len == exp_len, obs_len, exp_len);
        chk({tag, "_err_overflow"}, obs_ovf == exp_ovf, obs_ovf, exp_ovf);
        chk({tag, "_err_suspend"},  obs_sus == exp_sus, obs_sus, exp_sus);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},   txn_valid === 1'b0, txn_valid, 0);
        chk({tag, "_type"},    txn_type === 2'd0, txn_type, 0);
        chk({tag, "_head"},    txn_head === 8'd0, txn_head, 0);
        chk({tag, "_payload"}, txn_payload === 10'd0, txn_payload, 0);
        chk({tag, "_errs"}, {err_illegal, err_length, err_overflow, err_suspend} === 4'd0,
            {err_illegal, err_length, err_overflow, err_suspend}, 0);
    endtask

    initial begin
        logic [7:0] h;
        int         sel, hb, n, len;
        txn_s       e;
        rst = 1'b1; frame = 1'b0; serial = 1'b0; suspend = 1'b0; txn_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        force_ready = 1;
        idle(2, 1'b0);

        // Start frame
        send_frame(c_hdr_start, 8, 0, 16'h0, -1, 0, 1);
        check_errs("start");

        // Read frame with downstream stalled
        force_ready = 0; hold_ready = 1;
        send_frame(c_hdr_read, 8, 10, 16'h02B5, -1, 0, 0);
        idle(5, 1'b0);
        hold_ready = 0; force_ready = 1;
        idle(2, 1'b0);
        check_errs("read");

        // Config frame with a short suspend mid-payload
        send_frame(c_hdr_cfg, 8, 8, 16'h0096, 12, 3, 1);
        check_errs("cfg_sus");

        // Illegal header, then a suspend run reaching the limit
        send_frame(8'hFF, 8, 10, 16'h03FF, -1, 0, 1);
        idle(4, 1'b1);
        check_errs("illegal_sus");

        // Over-long config frame, then overflow cases
        send_frame(c_hdr_cfg, 8, 9, 16'h01A5, -1, 0, 1);
        force_ready = 0; hold_ready = 1;
        send_frame(c_hdr_start, 8, 0, 16'h0, -1, 0, 0);
        send_frame(c_hdr_start, 8, 0, 16'h0, -1, 0, 0);
        hold_ready = 0; force_ready = 1;
        idle(2, 1'b0);
        force_ready = 0; hold_ready = 1;
        send_frame(c_hdr_cfg, 8, 8, 16'h005C, -1, 0, 0);
        send_frame(c_hdr_start, 8, 0, 16'h0, -1, 0, 0);
        hold_ready = 0; force_ready = 1;
        idle(2, 1'b0);
        check_errs("len_ovf");

        // Reset in the middle of a header, with a transaction still pending
        force_ready = 0; hold_ready = 1;
        send_frame(c_hdr_start, 8, 0, 16'h0, -1, 0, 1);
        e.t = 2'd0; e.h = 8'd0; e.p = 10'd0;
        cyc(1'b1, rb(), 1'b0, 1'b0, e);
        for (int i = 0; i < 4; i++) cyc(1'b1, c_hdr_start[i], 1'b0, 1'b0, e);
        #2;
        rst = 1'b1; frame = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete(); busy = 0; sus_run = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold_ready = 0; force_ready = 1;
        idle(2, 1'b0);
        send_frame(c_hdr_start, 8, 0, 16'h0, -1, 0, 1);
        check_errs("postreset");

        // Randomised traffic
        force_ready = 0; rnd_sus = 1;
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 3);
            h = (sel == 0) ? c_hdr_start : (sel == 1) ? c_hdr_cfg : (sel == 2) ? c_hdr_read : 8'($urandom);
            len = (h == c_hdr_start) ? 0 : (h == c_hdr_cfg) ? 8 : (h == c_hdr_read) ? 10 : $urandom_range(0, 10);
            hb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 8;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : len;
            send_frame(h, hb, n, 16'($urandom), -1, 0, $urandom_range(0, 2));
        end
        rnd_sus = 0; force_ready = 1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1, 1'b0);
        idle(2, 1'b0);
        chk("drain_empty", exp_q.size() == 0, exp_q.size(), 0);
        check_errs("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
